vppm_slicer: RTL
================

Name: vppm_slicer

Overview:
- Demodulator stage directly downstream of the DC-level estimator (median/mean block).
- Slices signed ADC samples against the estimated threshold, with hysteresis.
- Counts high samples in the first and second half of each VPPM symbol period and decides the bit.
- Emits one bit per symbol, with a validity pulse and an ambiguity flag, to the frame/byte assembler.

Parameters:
- NBITS1, 16: sample and threshold width (signed).
- SPS, 32: samples per symbol. Must be even and at least 4.
- NBSPS, 6: counter width. Must satisfy 2**NBSPS > SPS.
- HYST, 8: hysteresis half-width, in LSBs.
- MARGIN, 2: minimum |cnt_b − cnt_a| for a non-ambiguous decision.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- thr_valid, input, 1: threshold is valid (estimator has completed).
- threshold, input, NBITS1: signed DC level from the estimator.
- sample_valid, input, 1: dataIn qualifier.
- dataIn, input, NBITS1: signed ADC sample.
- sym_sync, input, 1: marks the current valid sample as symbol sample 0.
- bit_out, output, 1: decided bit.
- bit_valid, output, 1: one-cycle strobe for bit_out and bit_err.
- bit_err, output, 1: ambiguous-symbol flag.
- sync_err, output, 1: one-cycle strobe when sym_sync arrives mid-symbol.
- locked, output, 1: high while the ACCUM state is active.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: bit_out, bit_valid, bit_err, sync_err, locked, slicer level, idx, cnt_a, cnt_b all 0; state IDLE.
- Reset mid-operation aborts the symbol; no bit_valid is issued for it.
- Slicer:
  - All comparisons use NBITS1+1 signed arithmetic: threshold±HYST, no overflow or wrap.
  - On sample_valid: lvl_next = 1 if dataIn > threshold+HYST; 0 if dataIn < threshold−HYST; otherwise the held level.
  - The level register updates only on sample_valid.
  - Counting uses lvl_next (the current sample's sliced value).
- States:
  - IDLE: locked=0. Go to WAIT_SYNC when thr_valid=1.
  - WAIT_SYNC: slicer runs, nothing is counted. On sample_valid & sym_sync → ACCUM with idx=1, cnt_a=lvl_next, cnt_b=0.
  - ACCUM: locked=1. For each sample_valid with sym_sync=0:
    - idx < SPS/2: cnt_a += lvl_next. Otherwise: cnt_b += lvl_next.
    - idx increments.
  - At idx == SPS−1 with sample_valid, decide using counts that include this sample. The decision is registered at the same edge:
    - bit_out = (cnt_b > cnt_a).
    - bit_err = (|cnt_b − cnt_a| < MARGIN).
    - bit_valid = 1 for exactly one cycle.
    - idx, cnt_a and cnt_b clear; stay in ACCUM (free-running symbol timing).
  - Latency: bit_valid is high in the cycle following the edge that accepts the SPS-th sample. Back-to-back symbols are supported with no dead cycle.
  - If cnt_b == cnt_a: bit_out=0 and bit_err=1 (since MARGIN ≥ 1).
- sym_sync with sample_valid in ACCUM:
  - At idx == 0: normal, no error.
  - At idx ≠ 0: sync_err pulses one cycle; the partial symbol is discarded (no bit_valid); the current sample becomes sample 0 (idx=1, cnt_a=lvl_next, cnt_b=0).
  - sym_sync without sample_valid is ignored.
- Simultaneous sym_sync on the SPS-th sample (idx == SPS−1): sync wins. sync_err=1, no bit_valid, restart.
- thr_valid = 0 in any state: next state IDLE; counters clear; no bit_valid for the partial symbol. The slicer level holds.
- bit_out and bit_err hold their values between strobes.
- Threshold changes mid-symbol are used immediately. No latching.

Test Plan:
- Reset: assert rst for 3 cycles with random inputs → all outputs 0, locked=0. Apply rst mid-symbol (idx=12) → no bit_valid afterwards until a new sym_sync plus 32 samples.
- Bit 0: threshold=1000, thr_valid=1, sym_sync on the first sample. 16 samples at 2000, then 16 at 0, continuous sample_valid → bit_valid one cycle after the 32nd accept, bit_out=0, bit_err=0, locked=1.
- Bit 1 back-to-back: 16 samples at 0, then 16 at 2000, immediately after the previous symbol → two consecutive strobes 32 cycles apart, bit_out 0 then 1.
- Hysteresis: threshold=1000, HYST=8, sequence 2000, 1005, 995, 992, 991 → sliced 1,1,1,1,0. Then 1008, 1009 → 0,1.
- Ambiguous: all 32 samples at 2000 → cnt_a=cnt_b=16, bit_valid=1, bit_out=0, bit_err=1. Repeat with 15 highs in the first half and 16 in the second (diff 1 < MARGIN) → bit_err=1, bit_out=1.
- Resync/threshold loss:
  - sym_sync at idx=10 → sync_err one cycle, no strobe at the old boundary, strobe 32 samples after the resync.
  - Drop thr_valid at idx=20 → locked=0, no strobe; requires a new sym_sync after thr_valid returns.
  - sample_valid gaps of 3 cycles between samples → same decisions as the continuous case.

Source files
------------

// File: rtl/vppm_slicer.sv
// VPPM slicer: hysteresis slicing of signed samples against the DC threshold,
// per-half-symbol high counts and one registered bit decision per symbol.
module vppm_slicer #(
   parameter int NBITS1 = 16,
   parameter int SPS    = 32,
   parameter int NBSPS  = 6,
   parameter int HYST   = 8,
   parameter int MARGIN = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     thr_valid,
   input  logic signed [NBITS1-1:0] threshold,
   input  logic                     sample_valid,
   input  logic signed [NBITS1-1:0] dataIn,
   input  logic                     sym_sync,
   output logic                     bit_out,
   output logic                     bit_valid,
   output logic                     bit_err,
   output logic                     sync_err,
   output logic                     locked
);

   typedef enum logic [1:0] {IDLE, WAIT_SYNC, ACCUM} state_t;

   localparam logic [NBSPS-1:0]         LAST     = NBSPS'(SPS - 1);
   localparam logic [NBSPS-1:0]         HALF     = NBSPS'(SPS / 2);
   localparam logic signed [NBITS1:0]   HYST_X   = (NBITS1 + 1)'(HYST);
   localparam logic [NBSPS:0]           MARGIN_X = (NBSPS + 1)'(MARGIN);

   state_t             r_state, w_state_nxt;
   logic               r_lvl;
   logic [NBSPS-1:0]   r_idx, r_cnt_a, r_cnt_b;
   logic [NBSPS-1:0]   w_idx_nxt, w_cnt_a_nxt, w_cnt_b_nxt;
   logic               w_bit_out_nxt, w_bit_err_nxt, w_bit_valid_nxt, w_sync_err_nxt;

   logic signed [NBITS1:0] w_data_x, w_thr_x, w_thr_hi, w_thr_lo;
   logic                   w_lvl_next;
   logic [NBSPS-1:0]       w_lvl_cnt, w_cnt_b_fin;
   logic [NBSPS:0]         w_diff;

   // One extra bit keeps threshold +/- HYST free of overflow at the rails.
   assign w_data_x = {dataIn[NBITS1-1], dataIn};
   assign w_thr_x  = {threshold[NBITS1-1], threshold};
   assign w_thr_hi = w_thr_x + HYST_X;
   assign w_thr_lo = w_thr_x - HYST_X;

   always_comb begin
      w_lvl_next = r_lvl;
      if (w_data_x > w_thr_hi)
         w_lvl_next = 1'b1;
      else if (w_data_x < w_thr_lo)
         w_lvl_next = 1'b0;
   end

   assign w_lvl_cnt   = NBSPS'(w_lvl_next);
   // The last sample always falls in the second half, so only cnt_b needs it.
   assign w_cnt_b_fin = r_cnt_b + w_lvl_cnt;
   assign w_diff      = (w_cnt_b_fin > r_cnt_a) ? {1'b0, w_cnt_b_fin - r_cnt_a}
                                                : {1'b0, r_cnt_a - w_cnt_b_fin};
   assign locked      = (r_state == ACCUM);

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_cnt_a_nxt     = r_cnt_a;
      w_cnt_b_nxt     = r_cnt_b;
      w_bit_out_nxt   = bit_out;
      w_bit_err_nxt   = bit_err;
      w_bit_valid_nxt = 1'b0;
      w_sync_err_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (thr_valid)
               w_state_nxt = WAIT_SYNC;
         end
         WAIT_SYNC: begin
            if (sample_valid && sym_sync) begin
               w_state_nxt = ACCUM;
               w_idx_nxt   = NBSPS'(1);
               w_cnt_a_nxt = w_lvl_cnt;
               w_cnt_b_nxt = '0;
            end
         end
         ACCUM: begin
            if (sample_valid) begin
               if (sym_sync) begin
                  // Resync takes priority, even on the symbol's last sample.
                  w_sync_err_nxt = (r_idx != '0);
                  w_idx_nxt      = NBSPS'(1);
                  w_cnt_a_nxt    = w_lvl_cnt;
                  w_cnt_b_nxt    = '0;
               end else if (r_idx == LAST) begin
                  w_bit_out_nxt   = (w_cnt_b_fin > r_cnt_a);
                  w_bit_err_nxt   = (w_diff < MARGIN_X);
                  w_bit_valid_nxt = 1'b1;
                  w_idx_nxt       = '0;
                  w_cnt_a_nxt     = '0;
                  w_cnt_b_nxt     = '0;
               end else begin
                  if (r_idx < HALF)
                     w_cnt_a_nxt = r_cnt_a + w_lvl_cnt;
                  else
                     w_cnt_b_nxt = r_cnt_b + w_lvl_cnt;
                  w_idx_nxt = r_idx + NBSPS'(1);
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (!thr_valid) begin
         w_state_nxt     = IDLE;
         w_idx_nxt       = '0;
         w_cnt_a_nxt     = '0;
         w_cnt_b_nxt     = '0;
         w_bit_out_nxt   = bit_out;
         w_bit_err_nxt   = bit_err;
         w_bit_valid_nxt = 1'b0;
         w_sync_err_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lvl     <= 1'b0;
         r_idx     <= '0;
         r_cnt_a   <= '0;
         r_cnt_b   <= '0;
         bit_out   <= 1'b0;
         bit_err   <= 1'b0;
         bit_valid <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         if (sample_valid && thr_valid)
            r_lvl <= w_lvl_next;
         r_idx     <= w_idx_nxt;
         r_cnt_a   <= w_cnt_a_nxt;
         r_cnt_b   <= w_cnt_b_nxt;
         bit_out   <= w_bit_out_nxt;
         bit_err   <= w_bit_err_nxt;
         bit_valid <= w_bit_valid_nxt;
         sync_err  <= w_sync_err_nxt;
      end
   end

endmodule
